// File: rtl/div_float_pkg.sv
// Shared types and constants for the single-precision divider.
// Holds the controller state encoding, exponent constants and the
// iteration count of the restoring mantissa divider.
package float_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int          EXP_BIAS = 127;
  localparam int          DIV_ITER = 26;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

endpackage

// File: rtl/div_float_if.sv
// Operand and result bus of the divider: start/done handshake, operands
// a and b, quotient c and the two exception flags.
interface div_float_if;

  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] c;
  logic        overflow;
  logic        div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, c, overflow, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, c, overflow, div_by_zero
  );

endinterface

// File: rtl/div_float_special.sv
// Combinational classifier for special divider operands.
// Denormals (exponent 0) count as zero. NaN wins over everything, then
// infinite dividend, then zero divisor, then zero results.
module fp_special_div
  import float_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        is_special_o,
  output logic [31:0] special_result_o,
  output logic        dbz_o
);

  logic aNan, bNan, aInf, bInf, aZero, bZero, sign;

  assign aNan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
  assign bNan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
  assign aInf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
  assign bInf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);
  assign aZero = (a_i[30:23] == 8'h00);
  assign bZero = (b_i[30:23] == 8'h00);
  assign sign  = a_i[31] ^ b_i[31];

  // Priority-ordered resolution of the special operand combinations
  always_comb begin
    is_special_o     = 1'b1;
    special_result_o = 32'd0;
    dbz_o            = 1'b0;
    if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
      special_result_o = QNAN;
    end else if (aInf) begin
      special_result_o = {sign, 8'hFF, 23'd0};
    end else if (bZero) begin
      special_result_o = {sign, 8'hFF, 23'd0};
      dbz_o            = 1'b1;
    end else if (aZero || bInf) begin
      special_result_o = {sign, 31'd0};
    end else begin
      is_special_o     = 1'b0;
    end
  end

endmodule

// File: rtl/div_float.sv
// Iterative single-precision IEEE-754 divider, c = a / b.
// Radix-2 restoring mantissa division over 26 quotient bits, then one
// normalise/round (nearest-even) step. Denormal inputs flush to zero,
// tiny results flush to signed zero without a flag.
// Build option: DIV_FLOAT_EARLY_EXIT_EN lets special operands skip
// straight from IDLE to DONE; without it they take the full path and
// the classifier result replaces the datapath result in NORM.
module div_float
  import float_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  div_float_if.slave bus
);

  localparam logic signed [9:0] ExpBias  = 10'(EXP_BIAS);
  localparam logic signed [9:0] ExpMax   = 10'(EXP_MAX);
  localparam logic        [4:0] IterLast = 5'(DIV_ITER);

  div_state_e       state_q;
  logic [4:0]       cnt_q;
  logic             sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]      mb_q;
  logic [24:0]      rem_q;
  logic [25:0]      q_q;
  logic             spec_q;
  logic [31:0]      specRes_q;
  logic             specDbz_q;
  logic [31:0]      c_q;
  logic             ovf_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  logic             isSpecial;
  logic [31:0]      specialResult;
  logic             specialDbz;
  logic             earlyExit;

  logic [24:0]      remNext_d;
  logic [25:0]      qNext_d;
  logic [31:0]      cNorm_d;
  logic             ovfNorm_d;
  logic             dbzNorm_d;

  fp_special_div u_special (
    .a_i              (bus.a),
    .b_i              (bus.b),
    .is_special_o     (isSpecial),
    .special_result_o (specialResult),
    .dbz_o            (specialDbz)
  );

`ifdef DIV_FLOAT_EARLY_EXIT_EN
  assign earlyExit = isSpecial;
`else
  assign earlyExit = 1'b0;
`endif

  // One restoring step: subtract the divisor when it fits, record the bit
  always_comb begin
    logic        geq;
    logic [24:0] remSub;
    geq       = rem_q >= {1'b0, mb_q};
    remSub    = rem_q - {1'b0, mb_q};
    remNext_d = geq ? {remSub[23:0], 1'b0} : {rem_q[23:0], 1'b0};
    qNext_d   = {q_q[24:0], geq};
  end

  // Normalise the quotient, round to nearest-even, range check the exponent
  always_comb begin
    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic              roundUp;
    logic [23:0]       mantRnd;
    logic signed [9:0] expAdj;
    logic signed [9:0] expRnd;
    if (q_q[25]) begin
      mant   = q_q[24:2];
      guard  = q_q[1];
      sticky = q_q[0] | (|rem_q);
      expAdj = exp_q;
    end else begin
      mant   = q_q[23:1];
      guard  = q_q[0];
      sticky = |rem_q;
      expAdj = exp_q - 10'sd1;
    end
    roundUp = guard & (sticky | mant[0]);
    mantRnd = {1'b0, mant} + {23'd0, roundUp};
    expRnd  = mantRnd[23] ? expAdj + 10'sd1 : expAdj;
    ovfNorm_d = 1'b0;
    dbzNorm_d = 1'b0;
    if (expRnd >= ExpMax) begin
      cNorm_d   = {sign_q, 8'hFF, 23'd0};
      ovfNorm_d = 1'b1;
    end else if (expRnd <= 10'sd0) begin
      cNorm_d   = {sign_q, 31'd0};
    end else begin
      cNorm_d   = {sign_q, expRnd[7:0], mantRnd[22:0]};
    end
    if (spec_q) begin
      cNorm_d   = specRes_q;
      ovfNorm_d = 1'b0;
      dbzNorm_d = specDbz_q;
    end
  end

  // Controller, iteration registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      sign_q    <= 1'b0;
      exp_q     <= 10'sd0;
      mb_q      <= 24'd0;
      rem_q     <= 25'd0;
      q_q       <= 26'd0;
      spec_q    <= 1'b0;
      specRes_q <= 32'd0;
      specDbz_q <= 1'b0;
      c_q       <= 32'd0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_q == CALC);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q    <= bus.a[31] ^ bus.b[31];
            exp_q     <= $signed({2'b00, bus.a[30:23]})
                         - $signed({2'b00, bus.b[30:23]}) + ExpBias;
            mb_q      <= {1'b1, bus.b[22:0]};
            rem_q     <= {2'b01, bus.a[22:0]};
            q_q       <= 26'd0;
            cnt_q     <= 5'd0;
            spec_q    <= isSpecial;
            specRes_q <= specialResult;
            specDbz_q <= specialDbz;
            if (earlyExit) begin
              c_q     <= specialResult;
              ovf_q   <= 1'b0;
              dbz_q   <= specialDbz;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt_q == IterLast) begin
            state_q <= NORM;
          end else begin
            rem_q <= remNext_d;
            q_q   <= qNext_d;
            cnt_q <= cnt_q + 5'd1;
          end
        end
        NORM: begin
          c_q     <= cNorm_d;
          ovf_q   <= ovfNorm_d;
          dbz_q   <= dbzNorm_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.c           = c_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/div_float.md
# div_float

Single-precision IEEE-754 divider that computes c = a / b with an iterative radix-2 restoring mantissa divider. It is the inverse-operation companion to the single-precision multiplier in the float arithmetic unit and sits beside it behind the same operand buses. It uses a start/done handshake instead of combinational output because division takes many cycles. Denormal inputs are flushed to zero, rounding is round-to-nearest-even, and special operands are resolved by a dedicated classifier.

## Interface
- No parameters; iteration count and constants come from the shared package.
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  32  dividend (IEEE single), sampled with start
- b  in  32  divisor (IEEE single), sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; c and the flags are valid from this cycle
- c  out  32  quotient; held until the next accepted start
- overflow  out  1  finite result exceeded the largest finite value; c forced to signed infinity
- div_by_zero  out  1  finite nonzero a divided by zero

## Operation
- States: IDLE, CALC, NORM, DONE.
  - IDLE to CALC on start.
  - CALC runs 26 iterations, then goes to NORM.
  - NORM to DONE.
  - DONE to IDLE unconditionally.
- start is ignored when not in IDLE.
- Operand capture in IDLE on start:
  - sign = a[31]^b[31].
  - ma = {1,a[22:0]} and mb = {1,b[22:0]}; a field with exponent 0 is treated as zero.
  - exp = {2'b0,ea} - {2'b0,eb} + 127, held in a 10-bit signed register.
- CALC: each iteration compares the 25-bit partial remainder against mb, subtracts if it is greater or equal, shifts left, and appends the quotient bit to q[25:0], MSB first (weight 2^0 down to 2^-25).
- NORM:
  - If q[25]=1: mantissa = q[24:2], guard = q[1], sticky = q[0] | (rem != 0).
  - If q[25]=0: mantissa = q[23:1], guard = q[0], sticky = (rem != 0), exp = exp - 1.
  - Rounding: increment when guard & (sticky | mantissa LSB). A mantissa carry-out increments exp.
  - If exp ≥ 255: c = {sign, 8'hFF, 0} and overflow = 1.
  - If exp ≤ 0: c = {sign, 31'b0} (underflow flush, no flag).
- Special operands, resolved by the classifier (NaN has priority):
  - Either operand NaN, 0/0, or inf/inf gives 32'h7FC00000.
  - Finite nonzero / 0 gives signed infinity and div_by_zero = 1.
  - inf / finite gives signed infinity.
  - 0 / nonzero and finite / inf give signed zero.
- Special results never set overflow.

## Timing
- Reset, asynchronous on rst_n low: state = IDLE; c = 0, overflow = 0, div_by_zero = 0, busy = 0, done = 0. All iteration registers are cleared.
- Reset during CALC or NORM aborts the operation. No done is produced, and the first start after release is accepted normally.
- Normal latency: with start sampled at edge 0, done is high for exactly the cycle after edge 28 (26 CALC edges, 1 NORM, 1 DONE entry).
- busy is high during CALC and NORM. It falls at the edge where done rises.
- When done=1, a new start presented in the same cycle is ignored, because the block is not yet in IDLE. It is accepted one cycle later.
- c, overflow and div_by_zero update only on the edge entering DONE and are stable otherwise.

## Configuration
- DIV_FLOAT_EARLY_EXIT_EN
  - Defined: a special operand combination jumps IDLE to DONE at the sampling edge. done is high in the next cycle (latency 1) and busy never asserts.
  - Undefined: special operands run the full 28-cycle path, and the classifier result overrides the datapath in NORM.

## Structure
- float_pkg holds:
  - the state enum typedef;
  - constants EXP_BIAS = 127, DIV_ITER = 26, QNAN = 32'h7FC00000, EXP_MAX = 255.
- One sub-module: fp_special_div, a combinational classifier. Inputs are a and b. Outputs are is_special, special_result[31:0] and dbz.

## Test plan
- 6.0 / 2.0 (0x40C00000 / 0x40000000) → c = 0x40400000; done exactly 28 cycles after start; busy high for 27 cycles.
- 1.0 / 3.0 (0x3F800000 / 0x40400000) → c = 0x3EAAAAAB (round-up path); -6.0 / 2.0 (0xC0C00000 / 0x40000000) → c = 0xC0400000.
- 0x7F000000 / 0x3E800000 → c = 0x7F800000, overflow = 1. 0x00800000 / 0x7F000000 → c = 0x00000000, overflow = 0.
- 1.0 / 0 → c = 0x7F800000, div_by_zero = 1; 0 / 0 → c = 0x7FC00000. With DIV_FLOAT_EARLY_EXIT_EN, done is high 1 cycle after start; without it, 28 cycles.
- Pulse rst_n low 10 cycles into CALC → all outputs 0 immediately and no done pulse. A start 2 cycles after release completes normally.
- start held high across a whole operation → exactly one accepted start per IDLE visit. start asserted during busy changes neither c nor the operands.
